// File: rtl/apb3_fifo_mailbox.sv
`default_nettype none
// ============================================================================
// Module      : apb3_fifo_mailbox
// Description : APB3 completer exposing a TX FIFO (firmware -> fabric stream)
//               and an RX FIFO (fabric stream -> firmware), with inserted wait
//               states, PSLVERR on bad accesses and a level interrupt.
// Ports       : PCLK/PRESETN          clock, async active-low reset
//               PSEL..PWDATA          APB3 request (PADDR[4:2] decoded)
//               PRDATA/PREADY/PSLVERR APB3 response, valid while PREADY=1
//               TX_DATA/VALID/READY   TX stream out (first-word-fall-through)
//               RX_DATA/VALID/READY   RX stream in (RX_READY registered)
//               INT                   registered level interrupt
// Registers   : 0x00 TXDATA W, 0x04 RXDATA R, 0x08 STATUS R,
//               0x0C IRQ_EN RW, 0x10 IRQ_ST R/W1C
// Revision    : 1.0 - initial release
// ============================================================================
module apb3_fifo_mailbox #(
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 16,
   parameter int EXTRA_WAIT = 0
) (
   input  logic              PCLK,
   input  logic              PRESETN,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [7:0]        PADDR,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic [DATA_W-1:0] TX_DATA,
   output logic              TX_VALID,
   input  logic              TX_READY,
   input  logic [DATA_W-1:0] RX_DATA,
   input  logic              RX_VALID,
   output logic              RX_READY,
   output logic              INT
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_pw = c_aw + 1;
   localparam logic [c_pw-1:0] c_depth = c_pw'(DEPTH);

   localparam logic [2:0] c_idx_txdata = 3'd0;
   localparam logic [2:0] c_idx_rxdata = 3'd1;
   localparam logic [2:0] c_idx_status = 3'd2;
   localparam logic [2:0] c_idx_irq_en = 3'd3;
   localparam logic [2:0] c_idx_irq_st = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t              state_q,    state_d;
   logic [2:0]          wcnt_q,     wcnt_d;
   logic                pready_q,   pready_d;
   logic                pslverr_q,  pslverr_d;
   logic [31:0]         prdata_q,   prdata_d;
   logic [2:0]          op_idx_q,   op_idx_d;
   logic                op_wr_q,    op_wr_d;
   logic [DATA_W-1:0]   op_data_q,  op_data_d;
   logic [2:0]          op_irq_q,   op_irq_d;
   logic [2:0]          irq_en_q,   irq_en_d;
   logic                err_q,      err_d;
   logic                int_q,      int_d;
   logic                rx_ready_q, rx_ready_d;
   logic [c_pw-1:0]     tx_wptr_q,  tx_wptr_d;
   logic [c_pw-1:0]     tx_rptr_q,  tx_rptr_d;
   logic [c_pw-1:0]     rx_wptr_q,  rx_wptr_d;
   logic [c_pw-1:0]     rx_rptr_q,  rx_rptr_d;

   logic [DATA_W-1:0]   tx_mem_q [DEPTH];
   logic [DATA_W-1:0]   rx_mem_q [DEPTH];

   logic [c_pw-1:0]     w_tx_count;
   logic [c_pw-1:0]     w_rx_count;
   logic [c_pw-1:0]     w_rx_count_nxt;
   logic                w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
   logic                w_commit;
   logic                w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
   logic [31:0]         w_rsp_data;
   logic                w_rsp_err;
   logic                w_go_resp;

   // Address bits outside [4:2] and high write-data bits carry no meaning.
   logic                w_unused_ok;
   assign w_unused_ok = &{1'b0, PADDR[7:5], PADDR[1:0], PWDATA};

   // ------------------------------------------------------------------------
   // FIFO status
   // ------------------------------------------------------------------------
   assign w_tx_count = tx_wptr_q - tx_rptr_q;
   assign w_rx_count = rx_wptr_q - rx_rptr_q;
   assign w_tx_empty = (w_tx_count == '0);
   assign w_tx_full  = (w_tx_count == c_depth);
   assign w_rx_empty = (w_rx_count == '0);
   assign w_rx_full  = (w_rx_count == c_depth);

   // The transfer's side effect lands on the edge that leaves RESP. An op
   // flagged as an error at RESP entry never touches the FIFOs or registers.
   assign w_commit  = (state_q == S_RESP);
   assign w_tx_push = w_commit && !pslverr_q && op_wr_q  && (op_idx_q == c_idx_txdata);
   assign w_rx_pop  = w_commit && !pslverr_q && !op_wr_q && (op_idx_q == c_idx_rxdata);
   assign w_tx_pop  = TX_VALID && TX_READY;
   assign w_rx_push = RX_VALID && rx_ready_q;

   // ------------------------------------------------------------------------
   // Response decode from the state seen on the RESP-entry edge
   // ------------------------------------------------------------------------
   always_comb begin
      w_rsp_data = '0;
      w_rsp_err  = 1'b0;
      case (PADDR[4:2])
         c_idx_txdata: begin
            if (PWRITE) w_rsp_err = w_tx_full;
            else        w_rsp_err = 1'b1;
         end
         c_idx_rxdata: begin
            if (PWRITE || w_rx_empty) w_rsp_err  = 1'b1;
            else                      w_rsp_data = 32'(rx_mem_q[rx_rptr_q[c_aw-1:0]]);
         end
         c_idx_status: begin
            if (PWRITE) w_rsp_err = 1'b1;
            else        w_rsp_data = {8'd0, 8'(w_rx_count), 8'(w_tx_count), 4'd0,
                                      w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};
         end
         c_idx_irq_en: begin
            if (!PWRITE) w_rsp_data = {29'd0, irq_en_q};
         end
         c_idx_irq_st: begin
            if (!PWRITE) w_rsp_data = {29'd0, err_q, w_tx_empty, !w_rx_empty};
         end
         default: w_rsp_err = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------------
   // Transfer FSM next state
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      op_idx_d  = op_idx_q;
      op_wr_d   = op_wr_q;
      op_data_d = op_data_q;
      op_irq_d  = op_irq_q;
      w_go_resp = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (PSEL && PENABLE) begin
               // With no extra wait the first access cycle already counts as
               // the wait, so RESP follows directly.
               if (EXTRA_WAIT == 0) begin
                  w_go_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  wcnt_d  = 3'(EXTRA_WAIT);
               end
            end
         end
         S_WAIT: begin
            if (!PSEL) begin
               // Initiator abandoned the transfer: drop it silently.
               state_d = S_IDLE;
               wcnt_d  = '0;
            end else if (wcnt_q == 3'd1) begin
               w_go_resp = 1'b1;
               wcnt_d    = '0;
            end else begin
               wcnt_d = wcnt_q - 3'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (w_go_resp) begin
         state_d   = S_RESP;
         pready_d  = 1'b1;
         pslverr_d = w_rsp_err;
         prdata_d  = w_rsp_err ? 32'd0 : w_rsp_data;
         op_idx_d  = PADDR[4:2];
         op_wr_d   = PWRITE;
         op_data_d = PWDATA[DATA_W-1:0];
         op_irq_d  = PWDATA[2:0];
      end
   end

   // ------------------------------------------------------------------------
   // Registers, pointers, interrupt
   // ------------------------------------------------------------------------
   always_comb begin
      irq_en_d  = irq_en_q;
      err_d     = err_q;
      tx_wptr_d = tx_wptr_q;
      tx_rptr_d = tx_rptr_q;
      rx_wptr_d = rx_wptr_q;
      rx_rptr_d = rx_rptr_q;

      if (w_tx_push) tx_wptr_d = tx_wptr_q + 1'b1;
      if (w_tx_pop)  tx_rptr_d = tx_rptr_q + 1'b1;
      if (w_rx_push) rx_wptr_d = rx_wptr_q + 1'b1;
      if (w_rx_pop)  rx_rptr_d = rx_rptr_q + 1'b1;

      if (w_commit) begin
         if (pslverr_q) begin
            err_d = 1'b1;
         end else if (op_wr_q && (op_idx_q == c_idx_irq_en)) begin
            irq_en_d = op_irq_q;
         end else if (op_wr_q && (op_idx_q == c_idx_irq_st) && op_irq_q[2]) begin
            err_d = 1'b0;
         end
      end

      w_rx_count_nxt = rx_wptr_d - rx_rptr_d;
      rx_ready_d     = (w_rx_count_nxt != c_depth);

      // Built from the current (already-updated) state, hence one cycle lag.
      int_d = |(irq_en_q & {err_q, w_tx_empty, !w_rx_empty});
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_q    <= S_IDLE;
         wcnt_q     <= '0;
         pready_q   <= 1'b0;
         pslverr_q  <= 1'b0;
         prdata_q   <= '0;
         op_idx_q   <= '0;
         op_wr_q    <= 1'b0;
         op_data_q  <= '0;
         op_irq_q   <= '0;
         irq_en_q   <= '0;
         err_q      <= 1'b0;
         int_q      <= 1'b0;
         rx_ready_q <= 1'b0;
         tx_wptr_q  <= '0;
         tx_rptr_q  <= '0;
         rx_wptr_q  <= '0;
         rx_rptr_q  <= '0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         pready_q   <= pready_d;
         pslverr_q  <= pslverr_d;
         prdata_q   <= prdata_d;
         op_idx_q   <= op_idx_d;
         op_wr_q    <= op_wr_d;
         op_data_q  <= op_data_d;
         op_irq_q   <= op_irq_d;
         irq_en_q   <= irq_en_d;
         err_q      <= err_d;
         int_q      <= int_d;
         rx_ready_q <= rx_ready_d;
         tx_wptr_q  <= tx_wptr_d;
         tx_rptr_q  <= tx_rptr_d;
         rx_wptr_q  <= rx_wptr_d;
         rx_rptr_q  <= rx_rptr_d;
      end
   end

   // FIFO storage needs no reset: pointers define which entries are live.
   always_ff @(posedge PCLK) begin
      if (w_tx_push) tx_mem_q[tx_wptr_q[c_aw-1:0]] <= op_data_q;
      if (w_rx_push) rx_mem_q[rx_wptr_q[c_aw-1:0]] <= RX_DATA;
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign PRDATA   = prdata_q;
   assign PREADY   = pready_q;
   assign PSLVERR  = pslverr_q;
   assign TX_VALID = !w_tx_empty;
   assign TX_DATA  = tx_mem_q[tx_rptr_q[c_aw-1:0]];
   assign RX_READY = rx_ready_q;
   assign INT      = int_q;

endmodule
`default_nettype wire

// File: tb/tb_apb3_fifo_mailbox.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb3_fifo_mailbox
// Description : Self-checking bench for apb3_fifo_mailbox. A queue-based
//               model predicts every output each cycle; directed sections pin
//               the model with literal values; a second instance covers
//               EXTRA_WAIT=3 and reset during a wait state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb3_fifo_mailbox;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int EW     = 0;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n   = 1'b0;
   logic        psel    = 1'b0;
   logic        psel3   = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite  = 1'b0;
   logic [7:0]  paddr   = '0;
   logic [31:0] pwdata  = '0;
   logic        tx_ready = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data  = '0;

   logic [31:0] prdata,  prdata3;
   logic        pready,  pready3, pslverr, pslverr3;
   logic [7:0]  tx_data, tx_data3;
   logic        tx_valid, tx_valid3, rx_ready, rx_ready3, irq, irq3;

   apb3_fifo_mailbox #(.DATA_W(DATA_W), .DEPTH(DEPTH), .EXTRA_WAIT(EW)) u_dut (
      .PCLK(clk), .PRESETN(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
      .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
      .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_READY(rx_ready), .INT(irq));

   apb3_fifo_mailbox #(.DATA_W(DATA_W), .DEPTH(DEPTH), .EXTRA_WAIT(3)) u_dut3 (
      .PCLK(clk), .PRESETN(rst_n), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3),
      .TX_DATA(tx_data3), .TX_VALID(tx_valid3), .TX_READY(tx_ready),
      .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_READY(rx_ready3), .INT(irq3));

   // ---------------- reference model state ----------------
   logic [7:0]  m_tx[$];
   logic [7:0]  m_rx[$];
   logic [2:0]  m_en;
   bit          m_err, m_int, m_rxrdy, m_pready, m_pslverr;
   logic [31:0] m_prdata;
   bit          op_err, op_wr;
   logic [2:0]  op_idx;
   logic [31:0] op_wd, op_rd;

   int          acc_k   = 0;     // current APB access-cycle number on u_dut, 0 = none
   bit          rand_fab = 1'b0;
   int          n_cmp = 0, n_bad = 0;

   logic [31:0] obs_prdata, obs3_prdata;
   logic        obs_pready, obs_pslverr, obs_txv, obs_rxr, obs_int;
   logic [7:0]  obs_txd, obs3_txd;
   logic        obs3_pready, obs3_pslverr, obs3_txv, obs3_rxr, obs3_int;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_tx.delete();
      m_rx.delete();
      m_en = 3'd0; m_err = 0; m_int = 0; m_rxrdy = 0;
      m_pready = 0; m_pslverr = 0; m_prdata = '0;
   endtask

   // What the register map says a transfer returns given the model state now.
   task automatic resp_compute(input logic [7:0] a, input bit w,
                               output bit e, output logic [31:0] d);
      e = 0; d = '0;
      case (a[4:2])
         3'd0: e = w ? (m_tx.size() == DEPTH) : 1'b1;
         3'd1: begin
            if (w || m_rx.size() == 0) e = 1;
            else d = {24'd0, m_rx[0]};
         end
         3'd2: begin
            if (w) e = 1;
            else begin
               d[0]     = (m_tx.size() == 0);
               d[1]     = (m_tx.size() == DEPTH);
               d[2]     = (m_rx.size() == 0);
               d[3]     = (m_rx.size() == DEPTH);
               d[15:8]  = 8'(m_tx.size());
               d[23:16] = 8'(m_rx.size());
            end
         end
         3'd3: if (!w) d = {29'd0, m_en};
         3'd4: if (!w) d = {29'd0, m_err, m_tx.size() == 0, m_rx.size() != 0};
         default: e = 1;
      endcase
   endtask

   // Model effect of one rising edge, from the inputs and model state before it.
   task automatic model_edge();
      bit tpop, rpush, nint, sample, commit, e;
      logic [31:0] d;
      tpop   = tx_ready && (m_tx.size() != 0);
      rpush  = rx_valid && m_rxrdy;
      nint   = (m_en[0] && m_rx.size() != 0) || (m_en[1] && m_tx.size() == 0) ||
               (m_en[2] && m_err);
      sample = psel && penable && (acc_k == 1 + EW);
      commit = (acc_k == 2 + EW);
      if (sample) begin
         resp_compute(paddr, pwrite, e, d);
         op_err = e; op_rd = d; op_idx = paddr[4:2]; op_wr = pwrite; op_wd = pwdata;
      end
      if (tpop)  void'(m_tx.pop_front());
      if (rpush) m_rx.push_back(rx_data);
      if (commit) begin
         if (op_err) m_err = 1;
         else case (op_idx)
            3'd0: if (op_wr) m_tx.push_back(op_wd[7:0]);
            3'd1: if (!op_wr) void'(m_rx.pop_front());
            3'd3: if (op_wr) m_en = op_wd[2:0];
            3'd4: if (op_wr && op_wd[2]) m_err = 0;
            default: ;
         endcase
      end
      m_int     = nint;
      m_rxrdy   = (m_rx.size() != DEPTH);
      m_pready  = sample;
      m_pslverr = sample ? op_err : 1'b0;
      m_prdata  = sample ? op_rd : 32'd0;
   endtask

   // One clock: compare at the falling edge, advance model at the rising edge.
   task automatic step();
      if (rand_fab) begin
         tx_ready = ($urandom_range(0, 3) == 0);
         rx_valid = 1'($urandom_range(0, 1));
         rx_data  = 8'($urandom);
      end
      if (!rst_n) model_reset();
      @(negedge clk);
      chk("pready",   {31'd0, pready},   {31'd0, m_pready});
      chk("pslverr",  {31'd0, pslverr},  {31'd0, m_pslverr});
      chk("prdata",   prdata,            m_prdata);
      chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_tx.size() != 0});
      if (m_tx.size() != 0) chk("tx_data", {24'd0, tx_data}, {24'd0, m_tx[0]});
      chk("rx_ready", {31'd0, rx_ready}, {31'd0, m_rxrdy});
      chk("int",      {31'd0, irq},      {31'd0, m_int});
      obs_prdata = prdata;  obs_pready = pready;   obs_pslverr = pslverr;
      obs_txv = tx_valid;   obs_txd = tx_data;     obs_rxr = rx_ready; obs_int = irq;
      obs3_prdata = prdata3; obs3_pready = pready3; obs3_pslverr = pslverr3;
      obs3_txv = tx_valid3;  obs3_txd = tx_data3;   obs3_rxr = rx_ready3; obs3_int = irq3;
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
   endtask

   task automatic apb(input logic [7:0] a, input bit w, input logic [31:0] d);
      psel = 1; penable = 0; paddr = a; pwrite = w; pwdata = d; acc_k = 0;
      step();
      penable = 1;
      for (int k = 1; k <= 2 + EW; k++) begin
         acc_k = k;
         step();
      end
      psel = 0; penable = 0; acc_k = 0;
   endtask

   logic [7:0] pushed [DEPTH];

   initial begin
      int got;
      model_reset();
      // ---------------- reset ----------------
      step(); step();
      chk("rst_prdata", obs_prdata, 32'd0);
      chk("rst_pready", {31'd0, obs_pready}, 32'd0);
      chk("rst_txv",    {31'd0, obs_txv}, 32'd0);
      chk("rst_rxr",    {31'd0, obs_rxr}, 32'd0);
      chk("rst_int",    {31'd0, obs_int}, 32'd0);
      rst_n = 1;
      step();
      chk("rxr_before_edge", {31'd0, obs_rxr}, 32'd0);
      step();
      chk("rxr_after_edge",  {31'd0, obs_rxr}, 32'd1);

      // ---------------- TX write and fall-through ----------------
      apb(8'h00, 1, 32'h0000_00A5);
      chk("wr_a5_pready",  {31'd0, obs_pready},  32'd1);
      chk("wr_a5_pslverr", {31'd0, obs_pslverr}, 32'd0);
      step();
      chk("tx_valid_a5", {31'd0, obs_txv}, 32'd1);
      chk("tx_data_a5",  {24'd0, obs_txd}, 32'hA5);
      apb(8'h08, 0, 0);
      chk("status_txcnt1", {24'd0, obs_prdata[15:8]}, 32'd1);

      // ---------------- TX fill, overflow, drain ----------------
      pushed[0] = 8'hA5;
      for (int i = 1; i < DEPTH; i++) begin
         pushed[i] = 8'(8'h30 + i);
         apb(8'h00, 1, {24'd0, pushed[i]});
      end
      apb(8'h00, 1, 32'h0000_00EE);
      chk("tx_overflow_pslverr", {31'd0, obs_pslverr}, 32'd1);
      apb(8'h08, 0, 0);
      chk("status_tx_full",  {31'd0, obs_prdata[1]}, 32'd1);
      chk("status_txcnt16",  {24'd0, obs_prdata[15:8]}, 32'd16);
      apb(8'h10, 0, 0);
      chk("irq_st_err", {31'd0, obs_prdata[2]}, 32'd1);
      tx_ready = 1; got = 0;
      for (int i = 0; i < 24; i++) begin
         step();
         if (obs_txv) begin
            if (got < DEPTH) chk("tx_pop_order", {24'd0, obs_txd}, {24'd0, pushed[got]});
            got++;
         end
      end
      chk("tx_pop_count", got, DEPTH);
      tx_ready = 0;

      // ---------------- RX reads ----------------
      rx_valid = 1; rx_data = 8'h11; step();
      rx_data = 8'h22; step();
      rx_valid = 0;
      apb(8'h04, 0, 0);
      chk("rx_rd_11", obs_prdata, 32'h11);
      apb(8'h04, 0, 0);
      chk("rx_rd_22", obs_prdata, 32'h22);
      apb(8'h04, 0, 0);
      chk("rx_empty_data",    obs_prdata, 32'd0);
      chk("rx_empty_pslverr", {31'd0, obs_pslverr}, 32'd1);
      chk("rx_ready_stays",   {31'd0, obs_rxr}, 32'd1);

      // ---------------- RX fill and back-pressure ----------------
      rx_valid = 1;
      for (int i = 0; i < DEPTH; i++) begin
         rx_data = 8'(8'h40 + i);
         step();
      end
      rx_valid = 0;
      step();
      chk("rx_full_ready0", {31'd0, obs_rxr}, 32'd0);
      rx_valid = 1; rx_data = 8'h99;
      apb(8'h04, 0, 0);
      chk("rx_full_rd", obs_prdata, 32'h40);
      step();
      chk("rx_ready_after_commit", {31'd0, obs_rxr}, 32'd1);
      rx_valid = 0;
      apb(8'h08, 0, 0);
      chk("status_rxcnt16", {24'd0, obs_prdata[23:16]}, 32'd16);
      chk("status_rx_full", {31'd0, obs_prdata[3]}, 32'd1);
      for (int i = 0; i < DEPTH; i++) apb(8'h04, 0, 0);
      chk("rx_last_word", obs_prdata, 32'h99);

      // ---------------- interrupts ----------------
      apb(8'h10, 1, 32'h4);
      apb(8'h0C, 1, 32'h1);
      rx_valid = 1; rx_data = 8'h77; step();
      rx_valid = 0; step(); step();
      chk("int_rx_not_empty", {31'd0, obs_int}, 32'd1);
      apb(8'h04, 0, 0);
      step(); step();
      chk("int_rx_drained", {31'd0, obs_int}, 32'd0);
      apb(8'h0C, 1, 32'h4);
      apb(8'h1C, 0, 0);
      chk("bad_addr_pslverr", {31'd0, obs_pslverr}, 32'd1);
      step(); step();
      chk("int_err", {31'd0, obs_int}, 32'd1);
      apb(8'h10, 1, 32'h4);
      step(); step();
      chk("int_err_cleared", {31'd0, obs_int}, 32'd0);

      // ---------------- randomized traffic ----------------
      rand_fab = 1;
      for (int n = 0; n < 400; n++) begin
         apb(8'($urandom_range(0, 7) << 2), 1'($urandom_range(0, 1)), $urandom);
         for (int g = $urandom_range(0, 2); g > 0; g--) step();
      end
      rand_fab = 0; tx_ready = 0; rx_valid = 0;
      step();

      // ---------------- EXTRA_WAIT=3 instance ----------------
      psel3 = 1; penable = 0; paddr = 8'h00; pwrite = 1; pwdata = 32'h5A;
      step();
      penable = 1;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk($sformatf("ew3_pready_%0d", k), {31'd0, obs3_pready}, {31'd0, k == 5});
      end
      chk("ew3_pslverr", {31'd0, obs3_pslverr}, 32'd0);
      psel3 = 0; penable = 0;
      step();
      chk("ew3_txv",  {31'd0, obs3_txv}, 32'd1);
      chk("ew3_txd",  {24'd0, obs3_txd}, 32'h5A);

      // reset asserted while u_dut3 is in its wait state during a TXDATA write
      psel3 = 1; penable = 0; paddr = 8'h00; pwrite = 1; pwdata = 32'h33;
      step();
      penable = 1;
      step(); step();
      rst_n = 0;
      step();
      chk("ew3_rst_prdata",  obs3_prdata, 32'd0);
      chk("ew3_rst_pready",  {31'd0, obs3_pready}, 32'd0);
      chk("ew3_rst_pslverr", {31'd0, obs3_pslverr}, 32'd0);
      chk("ew3_rst_txv",     {31'd0, obs3_txv}, 32'd0);
      chk("ew3_rst_rxr",     {31'd0, obs3_rxr}, 32'd0);
      chk("ew3_rst_int",     {31'd0, obs3_int}, 32'd0);
      psel3 = 0; penable = 0;
      step();
      rst_n = 1;
      step(); step(); step();
      chk("ew3_no_push", {31'd0, obs3_txv}, 32'd0);
      chk("ew3_rxr_up",  {31'd0, obs3_rxr}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
